bft_leaf_injector: RTL and testbench
====================================

Name: bft_leaf_injector

Overview:
- Leaf-side transmitter for the butterfly-fat-tree network.
- Accepts {destination, payload} words from the local PE through a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Formats each word as a network packet {valid, addr, payload} and holds it on the leaf's upward port until the attached switch acknowledges it.
- It is the source side of the addr/valid fields that the switch-level direction logic decodes.

Parameters:
- num_leaves, 16, number of leaves in the tree; power of 2, at least 2; A = $clog2(num_leaves).
- leaf_addr, 0, this leaf's own address; range 0..num_leaves-1.
- data_width, 32, payload width D.
- depth, 4, buffer capacity in packets; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid_i  in  1  PE offers a word
- in_addr_i  in  A  destination leaf address
- in_data_i  in  D  payload
- in_ready_o  out  1  buffer can take a word this cycle
- pkt_o  out  1+A+D  packet to switch: [A+D]=valid, [A+D-1:D]=addr, [D-1:0]=payload
- net_ack_i  in  1  switch consumed pkt_o this cycle
- loop_valid_o  out  1  self-addressed packet delivered locally (LOOPBACK_EN only; otherwise tied 0)
- loop_data_o  out  D  payload for loop_valid_o
- tx_count_o  out  16  packets sent to the network, wraps at 2^16
- overflow_o  out  1  sticky flag: in_valid_i was asserted while in_ready_o was 0

Behaviour:
- Reset values: all outputs 0 and occupancy 0. The asynchronous reset also drops any packet in flight: no ack is expected after reset and none is counted.
- Input handshake:
  - A word is accepted when in_valid_i && in_ready_o at a clock edge.
  - in_ready_o = (count < depth). It is registered from occupancy.
  - in_ready_o does not depend on net_ack_i in the same cycle: when the buffer is full, a simultaneous ack does not open a slot until the next cycle.
- Occupancy update: count increments on accept and decrements on send/loop. If both occur in the same cycle, count is unchanged.
- States:
  - EMPTY: count==0, pkt_o valid bit = 0.
  - PRESENT: head packet driven on pkt_o.
  - EMPTY→PRESENT on accept.
  - PRESENT stays in PRESENT while count>1 after pop, or while no ack is received.
  - PRESENT→EMPTY on ack when count==1 and no accept in the same cycle.
- Latency: a word accepted at edge t appears on pkt_o with the valid bit set after edge t, i.e. in cycle t+1 (1 cycle).
- Stability: while the valid bit is 1 and net_ack_i is 0, the addr and payload fields of pkt_o hold constant.
- On ack at edge t:
  - the next FIFO entry appears in cycle t+1, or the valid bit drops if the buffer is empty;
  - tx_count_o increments.
- Back-to-back: with continuous acks and continuous input, throughput is 1 packet/cycle.
- net_ack_i while the valid bit is 0 is ignored: no pop, no count.
- FIFO read and write pointers are log2(depth) bits and wrap modulo depth. Ordering is strictly FIFO.
- Packet fields:
  - addr = in_addr_i, unmodified; all A bits are meaningful.
  - The valid bit is never set on a slot that holds no data.
- overflow_o is set on a dropped offer and is cleared only by reset. The dropped word is not stored.

Optional Feature:
- Macro: BFT_LOOPBACK_EN.
- Defined:
  - A head packet whose addr == leaf_addr is not driven to the network; the pkt_o valid bit stays 0 for it.
  - That packet is popped in the cycle it reaches the head, with loop_valid_o = 1 for that one cycle and loop_data_o = its payload.
  - tx_count_o does not increment for it.
  - Network packets behind it then follow on subsequent cycles.
- Undefined:
  - Self-addressed packets are sent to the network like any other packet.
  - loop_valid_o and loop_data_o are constant 0.

Test Plan (num_leaves=16, leaf_addr=5, data_width=32, depth=4):
- Reset is released; one word (addr=9, data=0xA5A5_0001) is accepted at edge 1 → pkt_o = {1, 4'd9, 0xA5A5_0001} from cycle 2. It stays stable through 3 no-ack cycles. An ack in cycle 5 → valid bit 0 in cycle 6, tx_count_o = 1.
- 5 words are offered back-to-back with no ack → the first 4 are accepted and in_ready_o is 0 after the 4th. The 5th offer sets overflow_o. Acks on 4 consecutive cycles → packets emerge in order, and tx_count_o = 4.
- Buffer is full and an ack and an offer coincide in the same cycle → the offer is not accepted that cycle. in_ready_o = 1 the next cycle, and the next offer is accepted.
- Continuous input and continuous ack for 20 words → 20 packets at 1 per cycle in order, pointer wrap is exercised, tx_count_o = 20.
- reset_n is asserted while 3 packets are buffered and the head is unacked → valid bit 0 and count 0 immediately. After release, in_ready_o = 1 and tx_count_o = 0.
- BFT_LOOPBACK_EN is defined and the sequence addr=5, addr=3 is sent → loop_valid_o pulses with the first payload and no network valid is driven for it. The addr=3 packet appears on pkt_o the next cycle. tx_count_o increments only on the ack for addr=3.

Source files
------------

// File: rtl/bft_leaf_injector.sv
`default_nettype none
// ============================================================================
// Module   : bft_leaf_injector
// Purpose  : Butterfly-fat-tree leaf transmitter. Buffers PE words in a FIFO
//            and presents them to the upward switch port until acknowledged.
//            Optional macro BFT_LOOPBACK_EN delivers self-addressed packets
//            locally instead of sending them to the network.
// Revision : 1.0
// ============================================================================
module bft_leaf_injector #(
    parameter int NUM_LEAVES = 16,
    parameter int LEAF_ADDR  = 0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    in_valid_i,
    input  logic [$clog2(NUM_LEAVES)-1:0]           in_addr_i,
    input  logic [DATA_WIDTH-1:0]                   in_data_i,
    output logic                                    in_ready_o,
    output logic [$clog2(NUM_LEAVES)+DATA_WIDTH:0]  pkt_o,
    input  logic                                    net_ack_i,
    output logic                                    loop_valid_o,
    output logic [DATA_WIDTH-1:0]                   loop_data_o,
    output logic [15:0]                             tx_count_o,
    output logic                                    overflow_o
);

    localparam int A_W = $clog2(NUM_LEAVES);
    localparam int P_W = $clog2(DEPTH);
    localparam int C_W = P_W + 1;
    localparam logic [C_W-1:0] C_DEPTH = C_W'(DEPTH);

    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_t;

    if ((LEAF_ADDR < 0) || (LEAF_ADDR >= NUM_LEAVES)) begin : g_bad_leaf_addr
        $error("LEAF_ADDR out of range");
    end

    logic [A_W-1:0]        addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [P_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [P_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C_W-1:0]  count_q, count_d;
    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     tx_count_q, tx_count_d;

    logic [A_W-1:0]        head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  loop_pop;
    logic                  net_valid;
    logic                  net_pop;
    logic                  pop;

    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

`ifdef BFT_LOOPBACK_EN
    // A self-addressed head never reaches the network; it leaves the FIFO at once.
    assign loop_pop     = (state_q == PRESENT) && (head_addr == A_W'(LEAF_ADDR));
    assign loop_valid_o = loop_pop;
    assign loop_data_o  = loop_pop ? head_data : '0;
`else
    assign loop_pop     = 1'b0;
    assign loop_valid_o = 1'b0;
    assign loop_data_o  = '0;
`endif

    assign push      = in_valid_i && in_ready_q;
    assign net_valid = (state_q == PRESENT) && !loop_pop;
    assign net_pop   = net_valid && net_ack_i;
    assign pop       = net_pop || loop_pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + P_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + P_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + C_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - C_W'(1);
        end
        state_d    = (count_d != '0) ? PRESENT : EMPTY;
        // Ready looks only at next occupancy, so an ack on a full buffer opens a slot a cycle later.
        in_ready_d = (count_d < C_DEPTH);
        overflow_d = overflow_q | (in_valid_i & ~in_ready_q);
        tx_count_d = net_pop ? tx_count_q + 16'd1 : tx_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            tx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            overflow_q <= overflow_d;
            tx_count_q <= tx_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= in_addr_i;
            data_mem[wr_ptr_q] <= in_data_i;
        end
    end

    assign pkt_o      = net_valid ? {1'b1, head_addr, head_data} : '0;
    assign in_ready_o = in_ready_q;
    assign overflow_o = overflow_q;
    assign tx_count_o = tx_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bft_leaf_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bft_leaf_injector
// Purpose  : Self-checking bench for bft_leaf_injector (queue reference model,
//            vector table, directed corner sequences, random traffic).
// Revision : 1.0
// ============================================================================
module tb_bft_leaf_injector;

    localparam int NL   = 16;
    localparam int LEAF = 5;
    localparam int DW   = 32;
    localparam int DEP  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [3:0]  in_addr_i = '0;
    logic [31:0] in_data_i = '0;
    logic        in_ready_o;
    logic [36:0] pkt_o;
    logic        net_ack_i = 1'b0;
    logic        loop_valid_o;
    logic [31:0] loop_data_o;
    logic [15:0] tx_count_o;
    logic        overflow_o;

    bft_leaf_injector #(
        .NUM_LEAVES (NL),
        .LEAF_ADDR  (LEAF),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid_i   (in_valid_i),
        .in_addr_i    (in_addr_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .pkt_o        (pkt_o),
        .net_ack_i    (net_ack_i),
        .loop_valid_o (loop_valid_o),
        .loop_data_o  (loop_data_o),
        .tx_count_o   (tx_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffer is just a queue of {addr, data}.
    logic [3:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic [15:0] m_tx;
    logic        m_ovf;
    bit          m_fresh;

    logic [36:0] s_pkt;
    logic        s_rdy;
    logic [15:0] s_tx;
    logic        s_lv;
    logic [31:0] s_ld;

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic [31:0] d;
        logic        ack;
        logic        exp_rdy;
        logic [36:0] exp_pkt;
        logic [15:0] exp_tx;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(logic v, logic [3:0] a, logic [31:0] d, logic ack,
                                logic rdy, logic [36:0] pkt, logic [15:0] tx);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.ack = ack;
        r.exp_rdy = rdy; r.exp_pkt = pkt; r.exp_tx = tx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_addr.delete();
        q_data.delete();
        m_tx    = '0;
        m_ovf   = 1'b0;
        m_fresh = 1'b1;
    endtask

    // Drive one cycle of inputs, compare every output to the model, then clock.
    task automatic cycle(input logic v, input logic [3:0] a, input logic [31:0] d, input logic ack);
        bit          has;
        bit          self_hd;
        logic        e_rdy;
        logic [36:0] e_pkt;
        in_valid_i = v;
        in_addr_i  = a;
        in_data_i  = d;
        net_ack_i  = ack;
        #1;
        has     = (q_addr.size() > 0);
        self_hd = 1'b0;
`ifdef BFT_LOOPBACK_EN
        self_hd = has && (q_addr[0] == 4'(LEAF));
`endif
        e_rdy = !m_fresh && (q_addr.size() < DEP);
        e_pkt = (has && !self_hd) ? {1'b1, q_addr[0], q_data[0]} : '0;
        s_pkt = pkt_o; s_rdy = in_ready_o; s_tx = tx_count_o;
        s_lv  = loop_valid_o; s_ld = loop_data_o;
        chk("pkt_o", {27'd0, pkt_o}, {27'd0, e_pkt});
        chk("in_ready_o", {63'd0, in_ready_o}, {63'd0, e_rdy});
        chk("tx_count_o", {48'd0, tx_count_o}, {48'd0, m_tx});
        chk("overflow_o", {63'd0, overflow_o}, {63'd0, m_ovf});
        chk("loop_valid_o", {63'd0, loop_valid_o}, {63'd0, self_hd});
        chk("loop_data_o", {32'd0, loop_data_o}, {32'd0, (self_hd ? q_data[0] : 32'd0)});
        @(posedge clk);
        if (has && (self_hd || ack)) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            if (!self_hd) m_tx = m_tx + 16'd1;
        end
        if (v && e_rdy)  begin q_addr.push_back(a); q_data.push_back(d); end
        if (v && !e_rdy) m_ovf = 1'b1;
        m_fresh = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        in_valid_i = 1'b0;
        net_ack_i  = 1'b0;
        reset_n    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b0, '0, 16'd0);
        tbl[1] = mk(1'b1, 4'd9, 32'hA5A5_0001,  1'b0, 1'b1, '0, 16'd0);
        tbl[2] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b1, {1'b1, 4'd9, 32'hA5A5_0001}, 16'd0);
        tbl[3] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b1, {1'b1, 4'd9, 32'hA5A5_0001}, 16'd0);
        tbl[4] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b1, {1'b1, 4'd9, 32'hA5A5_0001}, 16'd0);
        tbl[5] = mk(1'b0, 4'd0, 32'h0,          1'b1, 1'b1, {1'b1, 4'd9, 32'hA5A5_0001}, 16'd0);
        tbl[6] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b1, '0, 16'd1);
        tbl[7] = mk(1'b0, 4'd0, 32'h0,          1'b1, 1'b1, '0, 16'd1);
        tbl[8] = mk(1'b0, 4'd0, 32'h0,          1'b0, 1'b1, '0, 16'd1);

        // Reset state and single packet hold/ack
        model_clear();
        #2;
        chk("reset pkt_o", {27'd0, pkt_o}, 64'd0);
        chk("reset in_ready_o", {63'd0, in_ready_o}, 64'd0);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].ack);
            chk($sformatf("tbl[%0d] pkt", i), {27'd0, s_pkt}, {27'd0, tbl[i].exp_pkt});
            chk($sformatf("tbl[%0d] rdy", i), {63'd0, s_rdy}, {63'd0, tbl[i].exp_rdy});
            chk($sformatf("tbl[%0d] tx", i), {48'd0, s_tx}, {48'd0, tbl[i].exp_tx});
        end

        // Fill past capacity, overflow, then drain in order
        do_reset();
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(10 + i), 32'h100 + 32'(i), 1'b0);
        chk("full in_ready", {63'd0, s_rdy}, 64'd0);
        chk("overflow sticky", {63'd0, overflow_o}, 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        chk("drain tx_count", {48'd0, s_tx}, 64'd4);

        // Ack and offer coincide on a full buffer
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 32'h200 + 32'(i), 1'b0);
        cycle(1'b1, 4'd7, 32'h0000_0BAD, 1'b1);
        chk("full+ack rdy", {63'd0, s_rdy}, 64'd0);
        cycle(1'b1, 4'd8, 32'h0000_0600, 1'b0);
        chk("slot reopens", {63'd0, s_rdy}, 64'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'd0, 32'h0, 1'b1);

        // Streaming at one packet per cycle with pointer wrap
        do_reset();
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'(i % 4), 32'h3000 + 32'(i), 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        chk("stream tx_count", {48'd0, s_tx}, 64'd20);

        // Asynchronous reset with buffered, unacked packets
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd12, 32'h4000 + 32'(i), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst pkt_o", {27'd0, pkt_o}, 64'd0);
        chk("async rst tx", {48'd0, tx_count_o}, 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        chk("post rst ready", {63'd0, s_rdy}, 64'd1);
        chk("post rst tx", {48'd0, s_tx}, 64'd0);

        // Self-addressed packet followed by a network packet
        do_reset();
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        cycle(1'b1, 4'(LEAF), 32'h5555_0005, 1'b0);
        cycle(1'b1, 4'd3, 32'h3333_0003, 1'b0);
`ifdef BFT_LOOPBACK_EN
        chk("loop pulse", {63'd0, s_lv}, 64'd1);
        chk("loop data", {32'd0, s_ld}, {32'd0, 32'h5555_0005});
        chk("loop no net valid", {63'd0, s_pkt[36]}, 64'd0);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        chk("after loop pkt", {27'd0, s_pkt}, {27'd0, 1'b1, 4'd3, 32'h3333_0003});
        chk("after loop tx", {48'd0, s_tx}, 64'd0);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        chk("loop ack tx", {48'd0, s_tx}, 64'd1);
`else
        chk("self to net", {27'd0, s_pkt}, {27'd0, 1'b1, 4'(LEAF), 32'h5555_0005});
        chk("no loop pulse", {63'd0, s_lv}, 64'd0);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b1);
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        chk("self tx count", {48'd0, s_tx}, 64'd2);
`endif

        // Random traffic against the queue model
        do_reset();
        cycle(1'b0, 4'd0, 32'h0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'd0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
